// File: rtl/alu_mdu_if.sv
// Request/response bundle between the EX stage and the ALU/MDU.
// The requester drives the op side; the unit drives handshake and results.
interface alu_mdu_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output in_valid, op, a, b, shamt, flush,
        input  in_ready, out_valid, result, zero, hi, lo, busy
    );

    modport slave (
        input  in_valid, op, a, b, shamt, flush,
        output in_ready, out_valid, result, zero, hi, lo, busy
    );
endinterface

// File: rtl/alu_mdu.sv
// EX-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops return next cycle; MD ops stall in_ready until DONE.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic clk,
    input logic rst,
    alu_mdu_if.slave bus
);
    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               dz_q, dz_d;
    logic               ov_q, ov_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept, sgn, dge;
    logic [WIDTH-1:0]   alu_r, ma, mb, dsub, quo, rem;
    logic [WIDTH:0]     madd, dtry;
    logic [2*WIDTH-1:0] mul_nx, div_nx, prod;

    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy      = ~bus.in_ready;
    assign bus.out_valid = ov_q;
    assign bus.result    = res_q;
    assign bus.zero      = (res_q == '0);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    assign accept = bus.in_valid & bus.in_ready & ~bus.flush;
    assign sgn    = (bus.op == 4'hC) || (bus.op == 4'hE);
    assign ma     = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mb     = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add: low half holds the unconsumed multiplier bits.
    assign madd   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mb_q} : '0);
    assign mul_nx = {madd, acc_q[WIDTH-1:1]};
    assign prod   = negq_q ? -mul_nx : mul_nx;

    // Restoring step: remainder in the high half, quotient shifts in low.
    assign dtry   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign dge    = dtry >= {1'b0, mb_q};
    assign dsub   = dtry[WIDTH-1:0] - mb_q;
    assign div_nx = {dge ? dsub : dtry[WIDTH-1:0], acc_q[WIDTH-2:0], dge};
    assign quo    = negq_q ? -div_nx[WIDTH-1:0] : div_nx[WIDTH-1:0];
    assign rem    = negr_q ? -div_nx[2*WIDTH-1:WIDTH]
                           : div_nx[2*WIDTH-1:WIDTH];

    always_comb begin
        alu_r = '0;
        unique case (bus.op)
            4'h0: alu_r = bus.a + bus.b;
            4'h1: alu_r = bus.a - bus.b;
            4'h2: alu_r = bus.a & bus.b;
            4'h3: alu_r = bus.a | bus.b;
            4'h4: alu_r = bus.a ^ bus.b;
            4'h5: alu_r = ~(bus.a | bus.b);
            4'h6: alu_r = {{(WIDTH-1){1'b0}},
                           $signed(bus.a) < $signed(bus.b)};
            4'h7: alu_r = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            4'h8: alu_r = bus.b << bus.shamt;
            4'h9: alu_r = bus.b >> bus.shamt;
            4'hA: alu_r = $signed(bus.b) >>> bus.shamt;
            4'hB: alu_r = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mb_d    = mb_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        ov_d    = 1'b0;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (bus.op[3:2] != 2'b11) begin
                        res_d = alu_r;
                        ov_d  = 1'b1;
                    end else begin
                        cnt_d  = CW'(WIDTH);
                        acc_d  = {{WIDTH{1'b0}}, ma};
                        mb_d   = mb;
                        negq_d = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        negr_d = sgn & bus.a[WIDTH-1];
                        dz_d   = 1'b0;
                        if (!bus.op[1]) begin
                            state_d = MUL;
                        end else begin
                            state_d = DIV;
                            // Divide by zero: one dummy step, raw a kept for hi.
                            if (bus.b == '0) begin
                                dz_d   = 1'b1;
                                cnt_d  = CW'(1);
                                acc_d  = {{WIDTH{1'b0}}, bus.a};
                                negq_d = 1'b0;
                                negr_d = 1'b0;
                            end
                        end
                    end
                end
            end
            MUL: begin
                acc_d = mul_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    ov_d    = 1'b1;
                    res_d   = '0;
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                end
            end
            DIV: begin
                acc_d = div_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    ov_d    = 1'b1;
                    res_d   = '0;
                    hi_d    = dz_q ? acc_q[WIDTH-1:0] : rem;
                    lo_d    = dz_q ? '1 : quo;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            ov_d    = 1'b0;
            res_d   = res_q;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mb_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mb_q    <= mb_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: ALU vector table, MD corner sequences, random
// stimulus against a plain-arithmetic model, and a 16-bit instance.
module tb_alu_mdu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(32)) bus ();
    alu_mdu_if #(.WIDTH(16)) bus16 ();

    alu_mdu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    alu_mdu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op,
        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        longint sa, sb;
        logic [63:0] w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~(a | b);
            4'h6: return (sa < sb) ? 32'd1 : 32'd0;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return b * (32'd1 << sh);
            4'h9: return b / (32'd1 << sh);
            4'hA: begin
                w = 64'(sb >>> sh);
                return w[31:0];
            end
            default: return {b[15:0], 16'h0000};
        endcase
    endfunction

    task automatic md_model(input logic [3:0] op, input logic [31:0] a,
        input logic [31:0] b, output logic [31:0] h, output logic [31:0] l);
        longint sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = '0; q = '0; r = '0;
        case (op)
            4'hC: p = 64'(sa * sb);
            4'hD: p = {32'h0, a} * {32'h0, b};
            4'hE: if (b != 0) begin
                q = 64'(sa / sb);
                r = 64'(sa % sb);
            end
            default: if (b != 0) begin
                q = {32'h0, a / b};
                r = {32'h0, a % b};
            end
        endcase
        if (op[1]) begin
            h = (b == 0) ? a : r[31:0];
            l = (b == 0) ? 32'hFFFFFFFF : q[31:0];
        end else begin
            h = p[63:32];
            l = p[31:0];
        end
    endtask

    task automatic run_md(input string nm, input logic [3:0] op,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] eh, input logic [31:0] el);
        int lat, exp_lat;
        logic rdy_bad;
        exp_lat = (op[1] && b == 0) ? 2 : 33;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        rdy_bad = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready || !bus.busy) rdy_bad = 1'b1;
            tick();
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " busy_window"}, {63'h0, rdy_bad}, 64'h0);
        chk({nm, " hi"}, {32'h0, bus.hi}, {32'h0, eh});
        chk({nm, " lo"}, {32'h0, bus.lo}, {32'h0, el});
        chk({nm, " result"}, {32'h0, bus.result}, 64'h0);
        chk({nm, " zero"}, {63'h0, bus.zero}, 64'h1);
        chk({nm, " ready_done"}, {63'h0, bus.in_ready}, 64'h1);
        tick();
        chk({nm, " pulse"}, {63'h0, bus.out_valid}, 64'h0);
    endtask

    task automatic run16(input string nm, input logic [3:0] op,
        input logic [15:0] a, input logic [15:0] b,
        input logic [15:0] eh, input logic [15:0] el, input int exp_lat);
        int lat;
        bus16.in_valid = 1'b1;
        bus16.op = op;
        bus16.a = a;
        bus16.b = b;
        tick();
        bus16.in_valid = 1'b0;
        lat = 1;
        while (!bus16.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " hi"}, {48'h0, bus16.hi}, {48'h0, eh});
        chk({nm, " lo"}, {48'h0, bus16.lo}, {48'h0, el});
        tick();
    endtask

    initial begin
        logic [31:0] eh, el, r;
        logic seen;
        int lat;

        tbl[0]  = '{4'h0, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0};
        tbl[1]  = '{4'h1, 32'h5, 32'h5, 5'd0, 32'h0, 1'b1};
        tbl[2]  = '{4'h6, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0};
        tbl[3]  = '{4'h7, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1};
        tbl[4]  = '{4'hA, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0};
        tbl[5]  = '{4'hB, 32'h0, 32'h1234, 5'd0, 32'h12340000, 1'b0};
        tbl[6]  = '{4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0};
        tbl[7]  = '{4'h3, 32'h0F0F0000, 32'h0000F0F0, 5'd0, 32'h0F0FF0F0, 1'b0};
        tbl[8]  = '{4'h4, 32'hFFFF0000, 32'hFF00FF00, 5'd0, 32'h00FFFF00, 1'b0};
        tbl[9]  = '{4'h5, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0};
        tbl[10] = '{4'h8, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0};
        tbl[11] = '{4'h9, 32'h0, 32'h80000000, 5'd31, 32'h1, 1'b0};
        tbl[12] = '{4'h0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1};
        tbl[13] = '{4'h1, 32'h0, 32'h1, 5'd0, 32'hFFFFFFFF, 1'b0};

        rst = 1'b1;
        bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        bus.shamt = 0; bus.flush = 0;
        bus16.in_valid = 0; bus16.op = 0; bus16.a = 0; bus16.b = 0;
        bus16.shamt = 0; bus16.flush = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("rst busy", {63'h0, bus.busy}, 64'h0);
        chk("rst out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rst zero", {63'h0, bus.zero}, 64'h1);
        chk("rst hilo", {bus.hi, bus.lo}, 64'h0);
        rst = 1'b0;
        tick();

        // Back-to-back single-cycle vectors
        for (int i = 0; i < 14; i++) begin
            bus.in_valid = 1'b1;
            bus.op = tbl[i].op;
            bus.a = tbl[i].a;
            bus.b = tbl[i].b;
            bus.shamt = tbl[i].sh;
            tick();
            chk($sformatf("vec%0d valid", i), {63'h0, bus.out_valid}, 64'h1);
            chk($sformatf("vec%0d result", i), {32'h0, bus.result},
                {32'h0, tbl[i].res});
            chk($sformatf("vec%0d zero", i), {63'h0, bus.zero},
                {63'h0, tbl[i].z});
        end
        bus.in_valid = 1'b0;
        tick();
        chk("sweep idle valid", {63'h0, bus.out_valid}, 64'h0);
        chk("sweep hilo held", {bus.hi, bus.lo}, 64'h0);

        // Random single-cycle ops, one per cycle
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'b1;
            bus.op = 4'($urandom_range(0, 11));
            bus.a = $urandom;
            bus.b = ($urandom_range(0, 3) == 0) ? bus.a : $urandom;
            bus.shamt = 5'($urandom);
            r = alu_model(bus.op, bus.a, bus.b, bus.shamt);
            tick();
            chk($sformatf("rnd%0d op%0h", i, bus.op), {31'h0, bus.out_valid,
                bus.result}, {32'h1, r});
        end
        bus.in_valid = 1'b0;
        tick();

        run_md("mult", 4'hC, 32'hFFFFFFF9, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_md("multu", 4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h1);
        run_md("div neg", 4'hE, 32'hFFFFFFF9, 32'h2,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu", 4'hF, 32'd100, 32'd7, 32'h2, 32'hE);
        run_md("div minint", 4'hE, 32'h80000000, 32'hFFFFFFFF,
               32'h0, 32'h80000000);
        run_md("divu by0", 4'hF, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
        run_md("div by0", 4'hE, 32'h80000001, 32'h0,
               32'h80000001, 32'hFFFFFFFF);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] op;
            logic [31:0] a, b;
            op = 4'hC + 4'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            md_model(op, a, b, eh, el);
            run_md($sformatf("rmd%0d op%0h", i, op), op, a, b, eh, el);
        end

        // Flush mid-multiply leaves hi/lo at the previous product
        run_md("pre flush", 4'hD, 32'd5, 32'd6, 32'h0, 32'h1E);
        bus.in_valid = 1'b1;
        bus.op = 4'hC;
        bus.a = 32'hFFFFFFF9;
        bus.b = 32'h3;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush ready", {63'h0, bus.in_ready}, 64'h1);
        seen = 1'b0;
        repeat (40) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        chk("flush no valid", {63'h0, seen}, 64'h0);
        chk("flush hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_001E);

        // Flush beside a new request: nothing accepted
        bus.in_valid = 1'b1;
        bus.op = 4'h0;
        bus.a = 32'h1;
        bus.b = 32'h1;
        bus.flush = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        chk("flush+req valid", {63'h0, bus.out_valid}, 64'h0);
        chk("flush+req ready", {63'h0, bus.in_ready}, 64'h1);

        // Request held through a busy period is taken on the DONE cycle
        bus.in_valid = 1'b1;
        bus.op = 4'hD;
        bus.a = 32'hFFFFFFFF;
        bus.b = 32'hFFFFFFFF;
        tick();
        bus.op = 4'h0;
        bus.a = 32'd2;
        bus.b = 32'd3;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("queued latency", 64'(lat), 64'd33);
        chk("queued hilo", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
        chk("queued ready", {63'h0, bus.in_ready}, 64'h1);
        tick();
        bus.in_valid = 1'b0;
        chk("queued op", {31'h0, bus.out_valid, bus.result},
            {32'h1, 32'd5});
        tick();

        // Asynchronous reset in the middle of a divide
        bus.in_valid = 1'b1;
        bus.op = 4'hE;
        bus.a = 32'd100;
        bus.b = 32'd7;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst busy", {63'h0, bus.busy}, 64'h0);
        chk("arst ready", {63'h0, bus.in_ready}, 64'h1);
        chk("arst hilo", {bus.hi, bus.lo}, 64'h0);
        chk("arst zero", {63'h0, bus.zero}, 64'h1);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        chk("arst no valid", {63'h0, seen}, 64'h0);

        // 16-bit instance
        run16("w16 mult", 4'hC, 16'hFFF9, 16'h3, 16'hFFFF, 16'hFFEB, 17);
        run16("w16 multu", 4'hD, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h1, 17);
        run16("w16 div", 4'hE, 16'hFFF9, 16'h2, 16'hFFFF, 16'hFFFD, 17);
        run16("w16 divu", 4'hF, 16'd100, 16'd7, 16'h2, 16'hE, 17);
        run16("w16 minint", 4'hE, 16'h8000, 16'hFFFF, 16'h0, 16'h8000, 17);
        run16("w16 by0", 4'hF, 16'h1234, 16'h0, 16'h1234, 16'hFFFF, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
